// File: rtl/gr_write_arbiter.sv
// ---------------------------------------------------------------------------
// gr_write_arbiter
//
// Shares the two general-register-file write ports among NUM_SRC result
// producers (ALU primary, ALU secondary, load unit, divider, ...).
//
// Behaviour summary:
//   - Round-robin search starting at r_ptr picks up to two eligible sources
//     per cycle. The first one goes to port 0. The next one whose destination
//     differs from port 0 goes to port 1.
//   - Requests to r0 are acknowledged at once and produce no write.
//   - Grants made in cycle N show up on the registered write ports in N+1.
//   - pend_mask tells the issue scoreboard which registers have a write
//     outstanding, either still requesting or sitting on a write port.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   wb_hold    suppresses all non-r0 grants this cycle
//   src_valid  per-source write request
//   src_dest   per-source destination, 5 bits per source
//   src_data   per-source write data, DW bits per source
//   src_ready  per-source accept (combinational)
//   wr0_*      registered write port 0 (enable / address / data)
//   wr1_*      registered write port 1 (enable / address / data)
//   pend_mask  one bit per architectural register with a pending write
// ---------------------------------------------------------------------------
module gr_write_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DW      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_hold,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [NUM_SRC*5-1:0]   src_dest,
  input  logic [NUM_SRC*DW-1:0]  src_data,
  output logic [NUM_SRC-1:0]     src_ready,
  output logic                   wr0_en,
  output logic [4:0]             wr0_addr,
  output logic [DW-1:0]          wr0_data,
  output logic                   wr1_en,
  output logic [4:0]             wr1_addr,
  output logic [DW-1:0]          wr1_data,
  output logic [31:0]            pend_mask
);

  localparam int PW = $clog2(NUM_SRC);

  // Unpacked views of the flattened source buses
  logic [4:0]         w_dest [NUM_SRC];
  logic [DW-1:0]      w_data [NUM_SRC];
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_r0;

  // Rotation pointer and registered write ports
  logic [PW-1:0] r_ptr;
  logic          r_wr0_en;
  logic [4:0]    r_wr0_addr;
  logic [DW-1:0] r_wr0_data;
  logic          r_wr1_en;
  logic [4:0]    r_wr1_addr;
  logic [DW-1:0] r_wr1_data;

  // Arbitration results
  logic               w_found0;
  logic               w_found1;
  logic [PW-1:0]      w_sel0;
  logic [PW-1:0]      w_sel1;
  logic [NUM_SRC-1:0] w_grant;
  logic [PW-1:0]      w_last;
  logic [PW-1:0]      w_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_dest[gi] = src_dest[5*gi +: 5];
      assign w_data[gi] = src_data[DW*gi +: DW];
      // r0 writes are discarded, so they are acknowledged even under hold
      assign w_r0[gi]   = src_valid[gi] && (w_dest[gi] == 5'd0);
      assign w_elig[gi] = src_valid[gi] && (w_dest[gi] != 5'd0) && !wb_hold && !rst;
    end
  endgenerate

  // Walk the sources in rotation order starting at r_ptr. A source whose
  // destination matches port 0 is skipped for port 1 so both ports never
  // target the same register; it simply retries next cycle.
  always_comb begin : p_search
    logic [PW:0] idx;
    idx      = '0;
    w_found0 = 1'b0;
    w_found1 = 1'b0;
    w_sel0   = '0;
    w_sel1   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_SRC)) begin
        idx = idx - (PW+1)'(NUM_SRC);
      end
      if (w_elig[idx[PW-1:0]]) begin
        if (!w_found0) begin
          w_found0 = 1'b1;
          w_sel0   = idx[PW-1:0];
        end else if (!w_found1 && (w_dest[idx[PW-1:0]] != w_dest[w_sel0])) begin
          w_found1 = 1'b1;
          w_sel1   = idx[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_found0) w_grant[w_sel0] = 1'b1;
    if (w_found1) w_grant[w_sel1] = 1'b1;
  end

  assign src_ready = rst ? '0 : (w_r0 | w_grant);

  // The next search starts just past the last source that won a port
  assign w_last     = w_found1 ? w_sel1 : w_sel0;
  assign w_ptr_next = (w_last == PW'(NUM_SRC-1)) ? '0 : w_last + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_wr0_en   <= 1'b0;
      r_wr0_addr <= '0;
      r_wr0_data <= '0;
      r_wr1_en   <= 1'b0;
      r_wr1_addr <= '0;
      r_wr1_data <= '0;
    end else begin
      r_wr0_en <= w_found0;
      r_wr1_en <= w_found1;
      // Address/data hold when a port is idle
      if (w_found0) begin
        r_wr0_addr <= w_dest[w_sel0];
        r_wr0_data <= w_data[w_sel0];
      end
      if (w_found1) begin
        r_wr1_addr <= w_dest[w_sel1];
        r_wr1_data <= w_data[w_sel1];
      end
      if (w_found0) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign wr0_en   = r_wr0_en;
  assign wr0_addr = r_wr0_addr;
  assign wr0_data = r_wr0_data;
  assign wr1_en   = r_wr1_en;
  assign wr1_addr = r_wr1_addr;
  assign wr1_data = r_wr1_data;

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i]) pend_mask[w_dest[i]] = 1'b1;
    end
    if (r_wr0_en) pend_mask[r_wr0_addr] = 1'b1;
    if (r_wr1_en) pend_mask[r_wr1_addr] = 1'b1;
    pend_mask[0] = 1'b0;
  end

  // Both ports writing the same register would make the result order-dependent
  always_ff @(posedge clk) begin
    if (!rst && r_wr0_en && r_wr1_en) begin
      assert (r_wr0_addr != r_wr1_addr)
        else $error("gr_write_arbiter: both write ports target r%0d", r_wr0_addr);
    end
  end

endmodule

// File: tb/tb_gr_write_arbiter.sv
module tb_gr_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_hold;
  logic [N-1:0]      src_valid;
  logic [N*5-1:0]    src_dest;
  logic [N*DW-1:0]   src_data;
  logic [N-1:0]      src_ready;
  logic              wr0_en;
  logic [4:0]        wr0_addr;
  logic [DW-1:0]     wr0_data;
  logic              wr1_en;
  logic [4:0]        wr1_addr;
  logic [DW-1:0]     wr1_data;
  logic [31:0]       pend_mask;

  gr_write_arbiter #(.NUM_SRC(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .wb_hold(wb_hold),
    .src_valid(src_valid), .src_dest(src_dest), .src_data(src_data),
    .src_ready(src_ready),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];

  // Reference state: what each source is currently requesting
  bit            m_valid [N];
  logic [4:0]    m_dest  [N];
  logic [DW-1:0] m_data  [N];
  int            m_ptr;
  logic [31:0]   m_inflight;
  int            mode;       // 0: drop after accept, 1: keep, 2: random refill
  logic [N-1:0]  dut_rdy;
  logic [31:0]   dut_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arbitration: list the eligible requesters in rotation order,
  // port 0 takes the head, port 1 takes the first later one with another dest.
  function automatic void model_arb(output logic [N-1:0] rdy, output int g0, output int g1);
    int order[$];
    rdy = '0;
    g0  = -1;
    g1  = -1;
    if (rst) return;
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_dest[i] == 5'd0) rdy[i] = 1'b1;
    if (wb_hold) return;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (m_valid[j] && m_dest[j] != 5'd0) order.push_back(j);
    end
    if (order.size() > 0) g0 = order[0];
    for (int n = 1; n < order.size(); n++)
      if (g1 < 0 && m_dest[order[n]] != m_dest[g0]) g1 = order[n];
    if (g0 >= 0) rdy[g0] = 1'b1;
    if (g1 >= 0) rdy[g1] = 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_valid[i]        = m_valid[i];
      src_dest[5*i +: 5]  = m_dest[i];
      src_data[DW*i +: DW] = m_data[i];
    end
  endtask

  task automatic new_req(input int i);
    m_valid[i] = 1'b1;
    m_dest[i]  = 5'($urandom_range(0, 9));
    m_data[i]  = $urandom;
  endtask

  // One clock: check combinational outputs mid-cycle, then commit the model
  task automatic cycle();
    logic [N-1:0] rdy;
    logic [31:0]  pend;
    int g0, g1, last;
    @(negedge clk);
    model_arb(rdy, g0, g1);
    pend = m_inflight;
    for (int i = 0; i < N; i++) if (m_valid[i]) pend[m_dest[i]] = 1'b1;
    pend[0] = 1'b0;
    dut_rdy  = src_ready;
    dut_pend = pend_mask;
    chk("src_ready", 64'(src_ready), 64'(rdy));
    chk("pend_mask", 64'(pend_mask), 64'(pend));
    @(posedge clk);
    m_inflight = '0;
    if (rst) begin
      m_ptr = 0;
    end else begin
      if (g0 >= 0) begin
        q0.push_back('{addr: m_dest[g0], data: m_data[g0]});
        m_inflight[m_dest[g0]] = 1'b1;
      end
      if (g1 >= 0) begin
        q1.push_back('{addr: m_dest[g1], data: m_data[g1]});
        m_inflight[m_dest[g1]] = 1'b1;
      end
      last = (g1 >= 0) ? g1 : g0;
      if (last >= 0) m_ptr = (last + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (rdy[i] && m_valid[i] && mode != 1) m_valid[i] = 1'b0;
      if (mode == 2 && !m_valid[i] && ($urandom_range(0, 2) == 0)) new_req(i);
    end
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    drive();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Monitor: every write the DUT presents must match the next expected one
  always @(negedge clk) begin
    if (wr0_en === 1'b1) begin
      if (q0.size() == 0) begin
        chk("wr0_unexpected", 64'(wr0_addr), 64'h3f);
      end else begin
        wr_t e;
        e = q0.pop_front();
        $display("wr0 addr=%0d data=%h", wr0_addr, wr0_data);
        chk("wr0_addr", 64'(wr0_addr), 64'(e.addr));
        chk("wr0_data", 64'(wr0_data), 64'(e.data));
      end
    end
    if (wr1_en === 1'b1) begin
      if (q1.size() == 0) begin
        chk("wr1_unexpected", 64'(wr1_addr), 64'h3f);
      end else begin
        wr_t e;
        e = q1.pop_front();
        $display("wr1 addr=%0d data=%h", wr1_addr, wr1_data);
        chk("wr1_addr", 64'(wr1_addr), 64'(e.addr));
        chk("wr1_data", 64'(wr1_data), 64'(e.data));
      end
    end
  end

  initial begin
    rst        = 1'b1;
    wb_hold    = 1'b0;
    m_ptr      = 0;
    m_inflight = '0;
    mode       = 0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_dest[i]  = '0;
      m_data[i]  = '0;
    end
    drive();

    // Reset state
    do_reset();
    cycle();
    chk("reset_wr0_en", 64'(wr0_en), 64'd0);
    chk("reset_wr1_en", 64'(wr1_en), 64'd0);
    chk("reset_pend", 64'(pend_mask), 64'd0);

    // Two sources, distinct dests
    m_valid[0] = 1; m_dest[0] = 5'd5; m_data[0] = 32'h11111111;
    m_valid[2] = 1; m_dest[2] = 5'd7; m_data[2] = 32'h22222222;
    drive();
    cycle();
    chk("two_src_ready", 64'(dut_rdy), 64'b0101);
    cycle();
    chk("two_src_wr0_addr", 64'(wr0_addr), 64'd5);
    chk("two_src_wr1_addr", 64'(wr1_addr), 64'd7);

    // All four held valid: rotation must alternate pairs
    do_reset();
    mode = 1;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1; m_dest[i] = 5'(i + 1); m_data[i] = 32'hA0 + i;
    end
    drive();
    cycle(); chk("rr_pair0", 64'(dut_rdy), 64'b0011);
    cycle(); chk("rr_pair1", 64'(dut_rdy), 64'b1100);
    cycle(); chk("rr_pair2", 64'(dut_rdy), 64'b0011);
    mode = 0;

    // Same-destination collision
    do_reset();
    m_valid[0] = 1; m_dest[0] = 5'd9;  m_data[0] = 32'hC0;
    m_valid[1] = 1; m_dest[1] = 5'd9;  m_data[1] = 32'hC1;
    m_valid[3] = 1; m_dest[3] = 5'd10; m_data[3] = 32'hC3;
    drive();
    cycle(); chk("collide_first", 64'(dut_rdy), 64'b1001);
    cycle(); chk("collide_second", 64'(dut_rdy), 64'b0010);
    cycle();

    // r0 request under hold
    do_reset();
    wb_hold = 1'b1;
    m_valid[1] = 1; m_dest[1] = 5'd0; m_data[1] = 32'hDEAD;
    drive();
    cycle(); chk("r0_hold_ready", 64'(dut_rdy), 64'b0010);
    cycle(); chk("r0_no_write", 64'({wr0_en, wr1_en}), 64'd0);

    // Held request stays pending
    m_valid[2] = 1; m_dest[2] = 5'd12; m_data[2] = 32'h1234;
    drive();
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("hold_ready", 64'(dut_rdy), 64'd0);
      chk("hold_pend12", 64'(dut_pend[12]), 64'd1);
    end
    wb_hold = 1'b0;
    cycle(); chk("hold_release", 64'(dut_rdy), 64'b0100);
    cycle(); chk("hold_inflight12", 64'(dut_pend[12]), 64'd1);
    cycle(); chk("hold_clear12", 64'(dut_pend[12]), 64'd0);

    // Randomized traffic with occasional hold and mid-operation reset
    mode = 2;
    for (int c = 0; c < 2000; c++) begin
      wb_hold = ($urandom_range(0, 9) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst     = 1'b0;
    wb_hold = 1'b0;
    mode    = 0;
    for (int c = 0; c < 12; c++) cycle();
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gr_write_arbiter.md
Name: gr_write_arbiter

Overview:
- Shares the two general-register-file write ports among NUM_SRC independent result producers: ALU primary, ALU secondary, load unit, and the multi-cycle divider.
- Arbitrates with a rotating (round-robin) priority. Discards writes to r0.
- Holds off same-destination collisions within a cycle.
- Drives registered write-port signals into the register-file update stage, plus a pending-write mask for the issue scoreboard.

Parameters:
- NUM_SRC, 4, number of requesting result sources (2..8).
- DW, 32, data width of a register write.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- wb_hold  in  1  when 1, no grants issued this cycle
- src_valid  in  NUM_SRC  per-source write request
- src_dest  in  NUM_SRC*5  per-source destination register; source i occupies bits [5i+4:5i]
- src_data  in  NUM_SRC*DW  per-source write data; source i occupies slice i
- src_ready  out  NUM_SRC  per-source accept; combinational from the current-cycle inputs and state
- wr0_en  out  1  write port 0 enable (registered)
- wr0_addr  out  5  write port 0 register index (registered)
- wr0_data  out  DW  write port 0 data (registered)
- wr1_en  out  1  write port 1 enable (registered)
- wr1_addr  out  5  write port 1 register index (registered)
- wr1_data  out  DW  write port 1 data (registered)
- pend_mask  out  32  bit r = 1 if any valid request or registered in-flight write targets r; bit 0 always 0

Behaviour:
- Reset (rst=1 at posedge):
  - ptr=0.
  - wr0_en=wr1_en=0; wr0_addr=wr1_addr=0; wr0_data=wr1_data=0.
  - src_ready is all 0 while rst=1.
- Handshake:
  - Transfer occurs when src_valid[i] & src_ready[i] at a posedge.
  - A source holds valid/dest/data stable until transferred.
  - ready may rise without valid being high, but is only meaningful when valid=1.
- r0 requests (valid, dest=0):
  - ready=1 in the same cycle, even when wb_hold=1.
  - Consume no port, produce no write, do not move ptr.
- Eligibility: valid, dest!=0, wb_hold=0.
- Search order: ptr, ptr+1, ... modulo NUM_SRC.
  - First eligible source → port 0.
  - Next eligible source whose dest differs from the port-0 dest → port 1.
  - Later eligible sources with the same dest as port 0 wait (ready=0).
  - At most 2 non-r0 grants per cycle.
- Latency:
  - A grant in cycle N appears on wrX_en/addr/data in cycle N+1 for exactly one cycle.
  - Ports with no grant have en=0; addr/data hold their previous values.
- Pointer update:
  - If there was ≥1 non-r0 grant, ptr ← (index of last granted source)+1 mod NUM_SRC.
  - Otherwise ptr is unchanged.
- Fairness: with all sources continuously valid and no collisions, every source is granted at least once per ceil(NUM_SRC/2) cycles. A requester never waits more than NUM_SRC cycles.
- Port ordering:
  - If wr0 and wr1 carry the same addr in the same cycle, that is an error. It cannot occur by construction; an assertion checks it.
  - Port 0 is always the earlier source in rotation order.
- pend_mask:
  - Combinational OR of onehot(src_dest[i]) over all valid i, plus onehot(wr0_addr) if wr0_en, plus onehot(wr1_addr) if wr1_en.
  - Bit 0 is forced to 0.
- wb_hold=1: all non-r0 ready=0; next-cycle wr0_en=wr1_en=0; ptr frozen.
- Reset mid-operation: pending requests are not accepted; the registered writes of that cycle are dropped (en cleared).

Test Plan:
- Reset, then src_valid=0000 → wr0_en=wr1_en=0, pend_mask=0, ptr=0.
- ptr=0. Src0 dest=5 data=0x11111111; src2 dest=7 data=0x22222222 → cycle N: ready=0101. Cycle N+1: wr0_en=1, wr0_addr=5, wr0_data=0x11111111; wr1_en=1, wr1_addr=7, wr1_data=0x22222222. ptr becomes 3.
- All 4 sources valid, dest 1,2,3,4, held after accept → grants are {0,1}, then {2,3}, then {0,1}. No source is skipped.
- ptr=0. Src0 and src1 both dest=9, src3 dest=10 → ready=1001 first cycle; port0=r9 from src0, port1=r10 from src3. Next cycle src1 is granted r9.
- Src1 dest=0 valid with wb_hold=1 → src_ready[1]=1 immediately, no wrX_en, ptr unchanged, pend_mask[0]=0.
- Src2 dest=12 valid, wb_hold=1 for 3 cycles → ready=0 and pend_mask[12]=1 throughout. After hold drops: granted; wr0_addr=12 the next cycle; pend_mask[12] clears one cycle after that.
